// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between a core load/store port and a synchronous SRAM with WAIT_STATES extra cycles.
// Optional macro DMEM_CTRL_WBUF_EN adds a one-entry posted write buffer (WDRAIN state).
`default_nettype none

module dmem_ctrl #(
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_in,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [31:0] data_out,
   output logic        stall,
   output logic        err,
   output logic [29:0] sram_addr,
   output logic [31:0] sram_wdata,
   output logic        sram_ce,
   output logic        sram_we,
   input  logic [31:0] sram_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;
`ifdef DMEM_CTRL_WBUF_EN
   localparam logic [1:0] S_WDRAIN = 2'd3;
`endif
   localparam logic [3:0] C_WAIT   = 4'(WAIT_STATES);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [3:0] r_cnt;
   logic       w_req;
   logic       w_valid;
   logic       w_post;

   assign w_req   = mem_read | mem_write;
   assign w_valid = (mem_read ^ mem_write) & (data_addr[1:0] == 2'b00);
`ifdef DMEM_CTRL_WBUF_EN
   assign w_post  = w_valid & mem_write;
`else
   assign w_post  = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_valid) begin
`ifdef DMEM_CTRL_WBUF_EN
               w_state_nxt = w_post ? S_WDRAIN : S_ACCESS;
`else
               w_state_nxt = S_ACCESS;
`endif
            end
         end
         S_ACCESS: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
`ifdef DMEM_CTRL_WBUF_EN
         S_WDRAIN: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_IDLE;
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // stall/err are gated by reset so they drop in the same cycle reset asserts.
   always_comb begin
      stall = 1'b0;
      err   = 1'b0;
      if (reset) begin
         case (r_state)
            S_IDLE: begin
               stall = w_valid & ~w_post;
               err   = w_req & ~w_valid;
            end
            S_ACCESS: begin
               stall = 1'b1;
            end
`ifdef DMEM_CTRL_WBUF_EN
            S_WDRAIN: begin
               stall = w_req;
            end
`endif
            default: begin
               stall = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= 4'd0;
         data_out   <= 32'd0;
         sram_addr  <= 30'd0;
         sram_wdata <= 32'd0;
         sram_ce    <= 1'b0;
         sram_we    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  sram_addr  <= data_addr[31:2];
                  sram_wdata <= data_in;
                  sram_we    <= mem_write;
                  sram_ce    <= 1'b1;
                  r_cnt      <= C_WAIT;
               end
            end
            S_ACCESS: begin
               if (r_cnt == 4'd0) begin
                  sram_ce <= 1'b0;
                  sram_we <= 1'b0;
                  if (!sram_we) begin
                     data_out <= sram_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
`ifdef DMEM_CTRL_WBUF_EN
            S_WDRAIN: begin
               if (r_cnt == 4'd0) begin
                  sram_ce <= 1'b0;
                  sram_we <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
`endif
            default: begin
               sram_ce <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: vector table, reset corner cases and random transactions against a word-level memory model.
`default_nettype none

module tb_dmem_ctrl;

   localparam int WS = 2;
`ifdef DMEM_CTRL_WBUF_EN
   localparam int WSTALL = 0;
`else
   localparam int WSTALL = WS + 2;
`endif

   logic        clk;
   logic        reset;
   logic [31:0] data_addr;
   logic [31:0] data_in;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] data_out;
   logic        stall;
   logic        err;
   logic [29:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        sram_ce;
   logic        sram_we;
   logic [31:0] sram_rdata;

   dmem_ctrl #(.WAIT_STATES(WS)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_addr  (data_addr),
      .data_in    (data_in),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .data_out   (data_out),
      .stall      (stall),
      .err        (err),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_ce    (sram_ce),
      .sram_we    (sram_we),
      .sram_rdata (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEADBEEF;
      return 32'hA5A5_0000 + 32'(i) * 32'h0000_0103 + 32'h7;
   endfunction

   // SRAM: combinational read of the addressed word, write on the clock edge.
   logic [31:0] sram_mem [0:63];
   logic        do_init;
   always @(posedge clk) begin
      if (do_init) begin
         for (int i = 0; i < 64; i++) sram_mem[i] <= init_word(i);
      end else if (sram_ce && sram_we) begin
         sram_mem[sram_addr[5:0]] <= sram_wdata;
      end
   end
   assign sram_rdata = sram_mem[sram_addr[5:0]];

   logic [31:0] ref_mem [0:63];
   int n_checks = 0;
   int n_pass   = 0;
   int m_ce, m_we, m_bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic sample_sram(input logic [31:0] a, input logic [31:0] d, input bit wr);
      if (sram_ce === 1'b1) begin
         m_ce++;
         if (sram_we === 1'b1) m_we++;
         if (sram_addr !== a[31:2] || sram_we !== wr || (wr && sram_wdata !== d)) m_bad++;
      end
   endtask

   task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input bit tail, output int stall_n, output logic err_s, output logic [31:0] dout_s);
      bit done;
      done = 0; stall_n = 0; err_s = 1'bx; dout_s = 32'hx;
      m_ce = 0; m_we = 0; m_bad = 0;
      mem_read = rd; mem_write = wr; data_addr = a; data_in = d;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         sample_sram(a, d, wr);
         if (stall === 1'b1) begin
            stall_n++;
         end else begin
            err_s = err; dout_s = data_out; done = 1;
            break;
         end
         @(posedge clk); #1;
      end
      check("txn_completes", 32'(done), 32'd1);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      if (tail) begin
         repeat (WS + 3) begin
            @(negedge clk);
            sample_sram(a, d, wr);
            @(posedge clk); #1;
         end
      end
   endtask

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          exp_err;
      int          exp_stall;
      int          exp_ce;
      int          exp_we;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int          st;
      logic        e;
      logic [31:0] dv;
      logic [31:0] model_dout;
      bit          ok;

      vecs[0] = '{1, 0, 32'h10, 32'h0,        0, WS + 2, WS + 1, 0,      32'hDEADBEEF};
      vecs[1] = '{0, 1, 32'h20, 32'h12345678, 0, WSTALL, WS + 1, WS + 1, 32'hDEADBEEF};
      vecs[2] = '{1, 0, 32'h13, 32'h0,        1, 0,      0,      0,      32'hDEADBEEF};
      vecs[3] = '{1, 1, 32'h20, 32'h55555555, 1, 0,      0,      0,      32'hDEADBEEF};
      vecs[4] = '{0, 1, 32'h40, 32'hCAFEF00D, 0, WSTALL, WS + 1, WS + 1, 32'hDEADBEEF};
      vecs[5] = '{1, 0, 32'h40, 32'h0,        0, WS + 2, WS + 1, 0,      32'hCAFEF00D};
      vecs[6] = '{1, 0, 32'h20, 32'h0,        0, WS + 2, WS + 1, 0,      32'h12345678};
      vecs[7] = '{0, 1, 32'h22, 32'h9999AAAA, 1, 0,      0,      0,      32'h12345678};
      vecs[8] = '{1, 0, 32'h00, 32'h0,        0, WS + 2, WS + 1, 0,      32'hA5A50007};

      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      do_init = 1'b1;
      reset = 1'b0;
      mem_read = 1'b1; mem_write = 1'b0; data_addr = 32'h10; data_in = 32'h0;
      repeat (2) @(posedge clk);
      #1 do_init = 1'b0;

      // reset state, with a valid request held to prove stall is gated
      @(negedge clk);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_ce", 32'(sram_ce), 32'd0);
      check("rst_we", 32'(sram_we), 32'd0);
      check("rst_dout", data_out, 32'd0);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_wdata", sram_wdata, 32'd0);
      @(posedge clk); #1;
      mem_read = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b1, st, e, dv);
         if ((vecs[i].rd ^ vecs[i].wr) && vecs[i].addr[1:0] == 2'b00 && vecs[i].wr)
            ref_mem[vecs[i].addr[7:2]] = vecs[i].wdata;
         check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d_stall_cycles", i), 32'(st), 32'(vecs[i].exp_stall));
         check($sformatf("vec%0d_ce_cycles", i), 32'(m_ce), 32'(vecs[i].exp_ce));
         check($sformatf("vec%0d_we_cycles", i), 32'(m_we), 32'(vecs[i].exp_we));
         check($sformatf("vec%0d_sram_bus", i), 32'(m_bad), 32'd0);
         check($sformatf("vec%0d_dout", i), dv, vecs[i].exp_dout);
      end

      // reset pulse in the second ACCESS cycle of a read
      mem_read = 1'b1; data_addr = 32'h30;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_ce_before", 32'(sram_ce), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("abort_stall", 32'(stall), 32'd0);
      check("abort_ce", 32'(sram_ce), 32'd0);
      check("abort_dout", data_out, 32'd0);
      mem_read = 1'b0;
      #1 reset = 1'b1;
      ok = 1;
      repeat (WS + 3) begin
         @(negedge clk);
         if (sram_ce !== 1'b0 || data_out !== 32'd0) ok = 0;
      end
      check("abort_no_capture", 32'(ok), 32'd1);
      @(posedge clk); #1;
      run_txn(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, st, e, dv);
      check("post_rst_stall_cycles", 32'(st), 32'(WS + 2));
      check("post_rst_dout", dv, ref_mem[12]);
      model_dout = ref_mem[12];

      // random back-to-back traffic against the word-level model
      for (int t = 0; t < 60; t++) begin
         int          kind;
         int          w;
         bit          rd, wr, valid;
         logic [31:0] a, d;
         kind = $urandom_range(0, 9);
         w    = $urandom_range(0, 63);
         d    = $urandom;
         a    = 32'(w) << 2;
         rd   = 1'($urandom_range(0, 1));
         wr   = !rd;
         if (kind == 0) a = a | 32'($urandom_range(1, 3));
         else if (kind == 1) begin rd = 1; wr = 1; end
         valid = (rd ^ wr) && a[1:0] == 2'b00;
         if (valid && wr) ref_mem[w] = d;
         if (valid && rd) model_dout = ref_mem[w];
         run_txn(rd, wr, a, d, 1'b0, st, e, dv);
         check($sformatf("rnd%0d_err", t), 32'(e), 32'(!valid));
         check($sformatf("rnd%0d_dout", t), dv, model_dout);
`ifndef DMEM_CTRL_WBUF_EN
         check($sformatf("rnd%0d_stall_cycles", t), 32'(st), valid ? 32'(WS + 2) : 32'd0);
         check($sformatf("rnd%0d_ce_cycles", t), 32'(m_ce), valid ? 32'(WS + 1) : 32'd0);
         check($sformatf("rnd%0d_sram_bus", t), 32'(m_bad), 32'd0);
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, range 0..15: extra SRAM cycles per access beyond the first.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_addr  input  32  byte address from core (ALU result).
REQ-005 SHALL have port data_in  input  32  core write data.
REQ-006 SHALL have port mem_read  input  1  core read request, held while stall=1.
REQ-007 SHALL have port mem_write  input  1  core write request, held while stall=1.
REQ-008 SHALL have port data_out  output  32  registered read data to core.
REQ-009 SHALL have port stall  output  1  combinational; core freezes its PC and register writeback while high.
REQ-010 SHALL have port err  output  1  combinational; request rejected.
REQ-011 SHALL have port sram_addr  output  30  registered word address, data_addr[31:2].
REQ-012 SHALL have port sram_wdata  output  32  registered write data.
REQ-013 SHALL have port sram_ce  output  1  registered SRAM chip enable.
REQ-014 SHALL have port sram_we  output  1  registered SRAM write enable, valid only with sram_ce.
REQ-015 SHALL have port sram_rdata  input  32  SRAM read data, valid during the last ACCESS cycle.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, DONE (plus WDRAIN under DMEM_CTRL_WBUF_EN).
REQ-017 Valid request SHALL mean exactly one of mem_read/mem_write high and data_addr[1:0]==0.
REQ-018 Invalid request in IDLE (both strobes high, or misaligned) SHALL drive err=1, stall=0, no SRAM access; data_out held.
REQ-019 Valid request in IDLE (cycle 0) SHALL drive stall=1, latch addr/data/direction, go to ACCESS.
REQ-020 ACCESS SHALL last WAIT_STATES+1 cycles (4-bit down-counter), with sram_ce=1 and sram_we=direction throughout.
REQ-021 Read: sram_rdata SHALL be captured into data_out at the edge ending the last ACCESS cycle.
REQ-022 DONE SHALL last one cycle with stall=0 and sram_ce=0; requests present in DONE SHALL be ignored, then return to IDLE.
REQ-023 stall SHALL equal (IDLE and valid request) or ACCESS; stall is therefore high for cycles 0..WAIT_STATES+1, and DONE = cycle WAIT_STATES+2.
REQ-024 Write SHALL leave data_out unchanged.
REQ-025 sram_ce SHALL be 0 in IDLE and DONE.

Reset
REQ-026 reset low SHALL immediately force IDLE, counter=0, data_out=0, sram_addr=0, sram_wdata=0, sram_ce=0, sram_we=0, and clear write buffer, regardless of clock.
REQ-027 Reset during ACCESS or WDRAIN SHALL abort the access; no capture; pending posted write discarded.
REQ-028 After release, first valid request SHALL be served per REQ-019..022.

Configuration
REQ-029 Macro DMEM_CTRL_WBUF_EN SHALL compile in a one-entry posted write buffer.
REQ-030 With macro: valid write in IDLE SHALL give stall=0, latch into buffer, enter WDRAIN for WAIT_STATES+1 cycles (sram_ce=1, sram_we=1), then IDLE.
REQ-031 With macro: any request arriving during WDRAIN SHALL see stall=1 and be accepted in IDLE after drain completes (read-after-write ordering preserved).
REQ-032 Without macro: writes SHALL follow REQ-019..022, identical to reads except for capture; WDRAIN absent.

Verification
REQ-033 Reset low mid-run -> same cycle stall=0, sram_ce=0, data_out=0x00000000.
REQ-034 WAIT_STATES=2, read 0x00000010, sram_rdata=0xDEADBEEF -> stall high cycles 0-3, sram_addr=0x4 with sram_ce cycles 1-3, data_out=0xDEADBEEF in cycle 4.
REQ-035 No macro, write 0x00000020 data 0x12345678 -> sram_we=1 cycles 1-3, sram_wdata=0x12345678, stall cycles 0-3, data_out unchanged.
REQ-036 Read 0x00000013, or mem_read=mem_write=1 -> err=1, stall=0, sram_ce never asserted.
REQ-037 Macro on, write 0x40=0xCAFEF00D then read 0x40 -> write stall=0, read stalls through drain plus read, data_out=0xCAFEF00D (SRAM model).
REQ-038 Reset pulse in ACCESS cycle 2 of a read -> no capture, IDLE; next read after release completes with normal latency.
